// File: rtl/lsu_store_buffer.sv
// Load/store unit with a posted-store FIFO, store-to-load forwarding and a flush FSM.
// Optional address-range fault checking is enabled by defining LSU_ADDR_CHECK_EN.
module lsu_store_buffer #(
  parameter int unsigned SB_DEPTH  = 4,
  parameter int unsigned ADDR_BITS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        resp_valid,
  output logic [15:0] resp_rdata,
  input  logic        flush_req,
  output logic        flush_done,
  output logic        sb_empty,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic        fault
);

  localparam int unsigned PtrW = $clog2(SB_DEPTH);
  localparam int unsigned CntW = $clog2(SB_DEPTH + 1);

  typedef enum logic [1:0] {StRun, StFlush, StDone} state_e;

  state_e                state_q, state_d;
  logic [ADDR_BITS-1:0]  sb_addr_q [SB_DEPTH];
  logic [15:0]           sb_data_q [SB_DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q, fwd_idx;
  logic [CntW-1:0]       count_q, count_d;
  logic                  resp_valid_q;
  logic [15:0]           resp_rdata_q, fwd_data, load_data;
  logic                  full, accept, load_acc, push, pop, addr_bad, fwd_hit;
  logic [ADDR_BITS-1:0]  req_waddr;

  assign req_waddr = req_addr[ADDR_BITS-1:0];
  assign full      = (count_q == CntW'(SB_DEPTH));
  assign sb_empty  = (count_q == '0);
  assign req_ready = (state_q == StRun) && !full && !flush_req;
  assign accept    = req_valid && req_ready;
  assign load_acc  = accept && !req_we;
  assign push      = accept && req_we && !addr_bad;
  // Any accepted request occupies the cycle, so drains only use otherwise idle cycles.
  assign pop       = !sb_empty && !accept && !rst;
  assign count_d   = count_q + CntW'(push) - CntW'(pop);

`ifdef LSU_ADDR_CHECK_EN
  logic fault_q;
  assign addr_bad = ((req_addr >> ADDR_BITS) != 16'd0);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) fault_q <= 1'b0;
    else     fault_q <= accept && addr_bad;
  end
  assign fault = fault_q;
`else
  logic unused_addr_hi;
  assign unused_addr_hi = ^(req_addr >> ADDR_BITS);
  assign addr_bad       = 1'b0;
  assign fault          = 1'b0;
`endif

  // Scan oldest to youngest so the youngest matching entry wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = '0;
    for (int unsigned i = 0; i < SB_DEPTH; i++) begin
      fwd_idx = rd_ptr_q + PtrW'(i);
      if ((CntW'(i) < count_q) && (sb_addr_q[fwd_idx] == req_waddr)) begin
        fwd_hit  = 1'b1;
        fwd_data = sb_data_q[fwd_idx];
      end
    end
  end

  assign load_data = addr_bad ? 16'h0000 : (fwd_hit ? fwd_data : mem_rdata);

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (load_acc) begin
      mem_addr[ADDR_BITS-1:0] = req_waddr;
    end else if (pop) begin
      mem_we                  = 1'b1;
      mem_addr[ADDR_BITS-1:0] = sb_addr_q[rd_ptr_q];
      mem_wdata               = sb_data_q[rd_ptr_q];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StRun:   if (flush_req) state_d = StFlush;
      StFlush: if (count_d == '0) state_d = StDone;
      StDone:  state_d = StRun;
      default: state_d = StRun;
    endcase
  end

  assign flush_done = (state_q == StDone);
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StRun;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      resp_valid_q <= load_acc;
      if (push)     wr_ptr_q     <= wr_ptr_q + 1'b1;
      if (pop)      rd_ptr_q     <= rd_ptr_q + 1'b1;
      if (load_acc) resp_rdata_q <= load_data;
    end
  end

  // Entry storage needs no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      sb_addr_q[wr_ptr_q] <= req_waddr;
      sb_data_q[wr_ptr_q] <= req_wdata;
    end
  end

endmodule

// File: tb/tb_lsu_store_buffer.sv
// Directed bench for lsu_store_buffer with a 256x16 behavioural data memory.
module tb_lsu_store_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [15:0] req_addr, req_wdata;
  logic        resp_valid;
  logic [15:0] resp_rdata;
  logic        flush_req, flush_done, sb_empty;
  logic        mem_we;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        fault;

  logic [15:0] mem [256];
  logic [7:0]  wlog [64];
  int          wr_total = 0;
  logic        mem_init = 1'b0;
  int          checks = 0;
  int          errors = 0;
  int          base;

  lsu_store_buffer dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .flush_req  (flush_req),
    .flush_done (flush_done),
    .sb_empty   (sb_empty),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .fault      (fault)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[7:0]];

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 16'h0000;
      mem[8'h05] <= 16'h1234;
      mem[8'h10] <= 16'h1111;
      mem_init   <= 1'b1;
    end else if (mem_we) begin
      mem[mem_addr[7:0]] <= mem_wdata;
      if (wr_total < 64) wlog[wr_total] <= mem_addr[7:0];
      wr_total <= wr_total + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic we, input logic [15:0] a, input logic [15:0] d);
    req_valid = v;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
  endtask

  initial begin
    rst = 1'b1;
    flush_req = 1'b0;
    drive(1'b0, 1'b0, 16'h0000, 16'h0000);
    repeat (2) tick();

    // Reset state
    check("rst_sb_empty", 32'(sb_empty), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_rdata", 32'(resp_rdata), 32'h0000);
    check("rst_flush_done", 32'(flush_done), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    rst = 1'b0;

    // 1: three buffered stores discarded by reset
    drive(1'b1, 1'b1, 16'h0020, 16'h0101); tick();
    drive(1'b1, 1'b1, 16'h0021, 16'h0202); tick();
    drive(1'b1, 1'b1, 16'h0022, 16'h0303); tick();
    check("t1_buffered", 32'(sb_empty), 32'd0);
    check("t1_no_drain_yet", 32'(wr_total), 32'd0);
    drive(1'b0, 1'b0, 16'h0000, 16'h0000);
    rst = 1'b1;
    #1;
    check("t1_rst_mem_we", 32'(mem_we), 32'd0);
    check("t1_rst_empty", 32'(sb_empty), 32'd1);
    tick();
    rst = 1'b0;
    tick();
    check("t1_no_writes", 32'(wr_total), 32'd0);
    check("t1_mem20", 32'(mem[8'h20]), 32'h0000);
    check("t1_mem22", 32'(mem[8'h22]), 32'h0000);

    // 2: forwarding to the next-cycle load
    drive(1'b1, 1'b1, 16'h0010, 16'hBEEF); tick();
    drive(1'b1, 1'b0, 16'h0010, 16'h0000);
    #1;
    check("t2_load_mem_we", 32'(mem_we), 32'd0);
    tick();
    drive(1'b0, 1'b0, 16'h0000, 16'h0000);
    check("t2_resp_valid", 32'(resp_valid), 32'd1);
    check("t2_resp_fwd", 32'(resp_rdata), 32'hBEEF);
    check("t2_mem_before_drain", 32'(mem[8'h10]), 32'h1111);
    tick();
    check("t2_resp_pulse", 32'(resp_valid), 32'd0);
    check("t2_resp_hold", 32'(resp_rdata), 32'hBEEF);
    check("t2_mem_drained", 32'(mem[8'h10]), 32'hBEEF);

    // 3: youngest matching entry wins
    drive(1'b1, 1'b1, 16'h00A5, 16'h0001); tick();
    drive(1'b1, 1'b1, 16'h00A5, 16'h0002); tick();
    drive(1'b1, 1'b0, 16'h00A5, 16'h0000); tick();
    drive(1'b0, 1'b0, 16'h0000, 16'h0000);
    check("t3_resp_youngest", 32'(resp_rdata), 32'h0002);
    tick();
    tick();
    check("t3_mem_a5", 32'(mem[8'hA5]), 32'h0002);
    check("t3_empty", 32'(sb_empty), 32'd1);

    // 4: fill to full across pointer wrap
    base = wr_total;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 16'h0030 + 16'(i), 16'h00C0 + 16'(i));
      tick();
    end
    drive(1'b1, 1'b1, 16'h0034, 16'h00C4);
    #1;
    check("t4_full_ready", 32'(req_ready), 32'd0);
    check("t4_full_drain", 32'(mem_we), 32'd1);
    tick();
    check("t4_ready_back", 32'(req_ready), 32'd1);
    drive(1'b0, 1'b0, 16'h0000, 16'h0000);
    repeat (3) tick();
    check("t4_writes", 32'(wr_total - base), 32'd4);
    for (int i = 0; i < 4; i++)
      check("t4_order", 32'(wlog[base + i]), 32'h30 + 32'(i));
    check("t4_mem33", 32'(mem[8'h33]), 32'h00C3);

    // 5: flush with three entries
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 16'h0040 + 16'(i), 16'h00D0 + 16'(i));
      tick();
    end
    base = wr_total;
    drive(1'b0, 1'b0, 16'h0000, 16'h0000);
    flush_req = 1'b1;
    #1;
    check("t5_ready_req", 32'(req_ready), 32'd0);
    check("t5_we0", 32'(mem_we), 32'd1);
    tick();
    check("t5_ready_flush", 32'(req_ready), 32'd0);
    check("t5_we1", 32'(mem_we), 32'd1);
    check("t5_done_early1", 32'(flush_done), 32'd0);
    tick();
    check("t5_we2", 32'(mem_we), 32'd1);
    check("t5_done_early2", 32'(flush_done), 32'd0);
    tick();
    check("t5_done", 32'(flush_done), 32'd1);
    check("t5_done_we", 32'(mem_we), 32'd0);
    check("t5_done_empty", 32'(sb_empty), 32'd1);
    flush_req = 1'b0;
    tick();
    check("t5_done_pulse", 32'(flush_done), 32'd0);
    check("t5_ready_run", 32'(req_ready), 32'd1);
    check("t5_writes", 32'(wr_total - base), 32'd3);
    check("t5_mem42", 32'(mem[8'h42]), 32'h00D2);

    // Flush with an already empty buffer
    flush_req = 1'b1;
    tick();
    check("fe_not_done", 32'(flush_done), 32'd0);
    tick();
    check("fe_done", 32'(flush_done), 32'd1);
    flush_req = 1'b0;
    tick();
    check("fe_done_pulse", 32'(flush_done), 32'd0);

    // 6: load with upper address bits set
    drive(1'b1, 1'b0, 16'h0105, 16'h0000); tick();
    drive(1'b0, 1'b0, 16'h0000, 16'h0000);
    check("t6_resp_valid", 32'(resp_valid), 32'd1);
`ifdef LSU_ADDR_CHECK_EN
    check("t6_fault", 32'(fault), 32'd1);
    check("t6_rdata", 32'(resp_rdata), 32'h0000);
`else
    check("t6_fault", 32'(fault), 32'd0);
    check("t6_rdata", 32'(resp_rdata), 32'h1234);
`endif
    tick();
    check("t6_fault_pulse", 32'(fault), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
